// File: rtl/sid_bus_writer_if.sv
// Command (valid/ready) and SID register bus signals of sid_bus_writer.
// slave is the writer's view; master is the command source / bus observer view.
interface sid_bus_writer_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          IN_VALID;
  logic          IN_READY;
  logic [4:0]    IN_ADDR;
  logic [7:0]    IN_DATA;
  logic          IN_DELAY;
  logic          WR;
  logic [4:0]    ADDR;
  logic [7:0]    DATA;
  logic          BUSY;
  logic [LW-1:0] LEVEL;

  modport master (
    output IN_VALID, IN_ADDR, IN_DATA, IN_DELAY,
    input  IN_READY, WR, ADDR, DATA, BUSY, LEVEL
  );

  modport slave (
    input  IN_VALID, IN_ADDR, IN_DATA, IN_DELAY,
    output IN_READY, WR, ADDR, DATA, BUSY, LEVEL
  );
endinterface

// File: rtl/sid_bus_writer.sv
// FIFO-buffered SID register writer: pops on TICK, WR one CLK later, IN_READY low when full.
// SID_WRITER_DELAY_EN adds delay entries ({addr,data} = TICK count) handled in a WAIT state.
module sid_bus_writer #(
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_TICKS  = 1
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            TICK,
  sid_bus_writer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
`ifdef SID_WRITER_DELAY_EN
  localparam int EW = 14;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_WAIT} state_t;
`else
  localparam int EW = 13;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;
`endif

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [EW-1:0] entry;
  logic [EW-1:0] head;
  logic          push;
  logic          pop;
  logic          advance;
  logic          load_bus;
  logic [12:0]   rem;
  logic [12:0]   rem_nxt;
  logic [4:0]    addr_q;
  logic [7:0]    data_q;
  state_t        state;
  state_t        state_nxt;

  assign bus.IN_READY = (level < LW'(FIFO_DEPTH));
  assign push         = bus.IN_VALID && bus.IN_READY;
  assign head         = mem[rd_ptr];

`ifdef SID_WRITER_DELAY_EN
  assign entry = {bus.IN_DELAY, bus.IN_ADDR, bus.IN_DATA};
`else
  logic unused_delay;
  assign unused_delay = bus.IN_DELAY;
  assign entry        = {bus.IN_ADDR, bus.IN_DATA};
`endif

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase
    end
  end

  // rem counts TICKs still owed before the next pop; a TICK in ISSUE counts
  // but never expires there, so WR can never be two cycles wide.
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    advance   = 1'b0;
    pop       = 1'b0;
    load_bus  = 1'b0;
    case (state)
      S_IDLE:  advance = TICK;
      S_ISSUE: begin
        state_nxt = S_GAP;
        if (TICK && rem != 13'd1) rem_nxt = rem - 13'd1;
      end
      default: begin
        if (TICK) begin
          if (rem == 13'd1) advance = 1'b1;
          else              rem_nxt = rem - 13'd1;
        end
      end
    endcase
    if (advance) begin
      if (level == '0) begin
        state_nxt = S_IDLE;
      end else begin
        pop = 1'b1;
`ifdef SID_WRITER_DELAY_EN
        if (head[13]) begin
          state_nxt = S_WAIT;
          rem_nxt   = (head[12:0] == 13'd0) ? 13'd1 : head[12:0];
        end else begin
          state_nxt = S_ISSUE;
          rem_nxt   = 13'(GAP_TICKS);
          load_bus  = 1'b1;
        end
`else
        state_nxt = S_ISSUE;
        rem_nxt   = 13'(GAP_TICKS);
        load_bus  = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rem    <= 13'd1;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      rem <= rem_nxt;
      if (load_bus) begin
        addr_q <= head[12:8];
        data_q <= head[7:0];
      end
    end
  end

  assign bus.WR    = (state == S_ISSUE);
  assign bus.ADDR  = addr_q;
  assign bus.DATA  = data_q;
  assign bus.BUSY  = (state != S_IDLE) || (level != '0);
  assign bus.LEVEL = level;
endmodule

// File: tb/tb_sid_bus_writer.sv
// Bench for sid_bus_writer: random TICK spacing, logged pushes/ticks/writes compared
// against a pop-schedule model derived from the TICK pacing rules.
module tb_sid_bus_writer;
  localparam int DEPTH = 4;
  localparam int GAP_T = 3;
`ifdef SID_WRITER_DELAY_EN
  localparam bit DLY_EN = 1'b1;
`else
  localparam bit DLY_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET_N;
  logic TICK;

  sid_bus_writer_if #(.FIFO_DEPTH(DEPTH)) bus ();

  sid_bus_writer #(.FIFO_DEPTH(DEPTH), .GAP_TICKS(GAP_T)) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .TICK   (TICK),
    .bus    (bus)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  int edge_no = 0;
  int tick_cd = 2;
  bit prev_wr = 1'b0;

  int          tick_q[$];
  int          push_e[$];
  logic [13:0] push_v[$];
  int          wr_e[$];
  logic [12:0] wr_v[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge CLK) edge_no <= edge_no + 1;

  // Write monitor: a WR seen after edge e belongs to the pop made at edge e.
  always @(negedge CLK) begin
    if (bus.WR === 1'b1) begin
      wr_e.push_back(edge_no);
      wr_v.push_back({bus.ADDR, bus.DATA});
      chk("wr_single_cycle", {31'd0, prev_wr}, 32'd0);
    end
    prev_wr = (bus.WR === 1'b1);
  end

  task automatic clear_logs();
    tick_q.delete();
    push_e.delete();
    push_v.delete();
    wr_e.delete();
    wr_v.delete();
  endtask

  task automatic cyc(input bit v, input logic [4:0] a, input logic [7:0] d,
                     input bit dl, input bit ten, output bit acc);
    @(negedge CLK);
    TICK = 1'b0;
    if (ten) begin
      if (tick_cd <= 1) begin
        TICK    = 1'b1;
        tick_cd = $urandom_range(5, 2);
      end else begin
        tick_cd--;
      end
    end
    bus.IN_VALID = v;
    bus.IN_ADDR  = a;
    bus.IN_DATA  = d;
    bus.IN_DELAY = dl;
    #1;
    acc = v && (bus.IN_READY === 1'b1);
    if (acc) begin
      push_e.push_back(edge_no + 1);
      push_v.push_back({DLY_EN ? dl : 1'b0, a, d});
    end
    if (TICK) tick_q.push_back(edge_no + 1);
  endtask

  task automatic idle(input int n, input bit ten);
    bit acc;
    repeat (n) cyc(1'b0, 5'd0, 8'd0, 1'b0, ten, acc);
  endtask

  task automatic push_cmd(input logic [4:0] a, input logic [7:0] d, input bit dl, input bit ten);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      cyc(1'b1, a, d, dl, ten, acc);
      n++;
    end
    chk("push_accepted", {31'd0, acc}, 32'd1);
  endtask

  // Each pop lands on the first TICK strictly after its push edge that is also
  // at least `req` TICKs after the previous pop (GAP_T for writes, max(N,1) for delays).
  task automatic check_log(input string tag);
    int ip;
    int i;
    int req;
    int ee[$];
    logic [12:0] ev[$];
    ip = -1;
    req = 1;
    foreach (push_e[k]) begin
      i = ip + req;
      while (i < tick_q.size() && tick_q[i] <= push_e[k]) i++;
      if (i >= tick_q.size()) break;
      if (push_v[k][13]) begin
        req = (push_v[k][12:0] == 13'd0) ? 1 : int'(push_v[k][12:0]);
      end else begin
        ee.push_back(tick_q[i]);
        ev.push_back(push_v[k][12:0]);
        req = GAP_T;
      end
      ip = i;
    end
    chk({tag, "_wr_count"}, wr_e.size(), ee.size());
    for (int k = 0; k < ee.size() && k < wr_e.size(); k++) begin
      chk({tag, "_wr_edge"}, wr_e[k], ee[k]);
      chk({tag, "_wr_addr_data"}, {19'd0, wr_v[k]}, {19'd0, ev[k]});
    end
  endtask

  initial begin
    bit acc;
    bit saw;
    logic [12:0] att[6];

    // Reset held with IN_VALID high: nothing enters, nothing is written.
    RESET_N      = 1'b0;
    TICK         = 1'b0;
    bus.IN_VALID = 1'b1;
    bus.IN_ADDR  = 5'h1F;
    bus.IN_DATA  = 8'hFF;
    bus.IN_DELAY = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      TICK = ~TICK;
      #1;
      chk("reset_in_ready", {31'd0, bus.IN_READY}, 32'd1);
      chk("reset_level", {29'd0, bus.LEVEL}, 32'd0);
      chk("reset_wr", {31'd0, bus.WR}, 32'd0);
      chk("reset_busy", {31'd0, bus.BUSY}, 32'd0);
      chk("reset_addr_data", {19'd0, bus.ADDR, bus.DATA}, 32'd0);
    end
    @(negedge CLK);
    RESET_N      = 1'b1;
    bus.IN_VALID = 1'b0;
    TICK         = 1'b0;
    clear_logs();
    idle(3, 1'b1);
    push_cmd(5'h04, 8'h21, 1'b0, 1'b1);
    idle(20, 1'b1);
    check_log("first");
    chk("first_count", wr_e.size(), 1);
    if (wr_v.size() > 0) chk("first_value", {19'd0, wr_v[0]}, 32'h0421);

    // Pacing: five back-to-back writes, FIFO kept busy.
    clear_logs();
    for (int k = 0; k < 5; k++) push_cmd(5'($urandom), 8'($urandom), 1'b0, 1'b1);
    idle(120, 1'b1);
    check_log("pace");
    chk("pace_count", wr_e.size(), 5);
    chk("pace_busy_done", {31'd0, bus.BUSY}, 32'd0);

    // Full: TICK held low, six single-cycle attempts, only four fit.
    clear_logs();
    for (int k = 0; k < 6; k++) begin
      att[k] = 13'($urandom);
      cyc(1'b1, att[k][12:8], att[k][7:0], 1'b0, 1'b0, acc);
      chk("full_accept", {31'd0, acc}, (k < 4) ? 32'd1 : 32'd0);
    end
    idle(1, 1'b0);
    chk("full_in_ready", {31'd0, bus.IN_READY}, 32'd0);
    chk("full_level", {29'd0, bus.LEVEL}, 32'd4);
    chk("full_busy", {31'd0, bus.BUSY}, 32'd1);
    idle(100, 1'b1);
    check_log("full");
    chk("full_count", wr_e.size(), 4);
    for (int k = 0; k < 4 && k < wr_v.size(); k++)
      chk("full_order", {19'd0, wr_v[k]}, {19'd0, att[k]});

    // Random traffic with random idle gaps; IN_DELAY is noise when the feature is off.
    clear_logs();
    repeat (20) begin
      push_cmd(5'($urandom), 8'($urandom), DLY_EN ? 1'b0 : 1'($urandom), 1'b1);
      idle($urandom_range(12, 0), 1'b1);
    end
    idle(120, 1'b1);
    check_log("rand");

`ifdef SID_WRITER_DELAY_EN
    // Delay entries: N=10 and N=0 (behaves as 1).
    clear_logs();
    push_cmd(5'h01, 8'h11, 1'b0, 1'b1);
    push_cmd(5'h00, 8'd10, 1'b1, 1'b1);
    push_cmd(5'h02, 8'h22, 1'b0, 1'b1);
    push_cmd(5'h00, 8'd0, 1'b1, 1'b1);
    push_cmd(5'h03, 8'h33, 1'b0, 1'b1);
    idle(200, 1'b1);
    check_log("delay");
    chk("delay_count", wr_e.size(), 3);
`endif

    // Reset mid-GAP with three entries still queued.
    clear_logs();
    for (int k = 0; k < 4; k++) push_cmd(5'($urandom), 8'($urandom), 1'b0, 1'b0);
    saw = 1'b0;
    for (int n = 0; n < 100 && !saw; n++) begin
      cyc(1'b0, 5'd0, 8'd0, 1'b0, 1'b1, acc);
      saw = (bus.WR === 1'b1);
    end
    chk("mid_first_wr", {31'd0, saw}, 32'd1);
    idle(1, 1'b1);
    chk("mid_level_before", {29'd0, bus.LEVEL}, 32'd3);
    @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    chk("mid_rst_wr", {31'd0, bus.WR}, 32'd0);
    chk("mid_rst_level", {29'd0, bus.LEVEL}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.BUSY}, 32'd0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    clear_logs();
    idle(60, 1'b1);
    chk("mid_no_wr", wr_e.size(), 0);
    chk("mid_idle_busy", {31'd0, bus.BUSY}, 32'd0);
    push_cmd(5'h1F, 8'hA5, 1'b0, 1'b1);
    idle(30, 1'b1);
    check_log("mid_after");
    chk("mid_after_count", wr_e.size(), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
